// File: rtl/mandelbrot_pixel_writer.sv
// Pulls iteration-count bursts from the Mandelbrot engine, colour-maps them into a pixel FIFO and
// streams pixels to the frame buffer. Define PIXEL_WRITER_PALETTE_EN for RGB332 colour, else gray.
module mandelbrot_pixel_writer #(
    parameter int unsigned SET_SIZE   = 1,
    parameter int unsigned MAX_ITER   = 255,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        eng_ready,
    input  logic [31:0] eng_data,
    input  logic        eng_frame_ready,
    input  logic [20:0] total_pixels,
    input  logic        fb_busy,
    output logic        send_data,
    output logic        clear_frame,
    output logic        fb_we,
    output logic [20:0] fb_addr,
    output logic [7:0]  fb_wdata,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StReq, StGap, StRecv} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  beat_q, beat_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [20:0]    pix_q, pix_d, total_q, total_d, limit;
    logic           clr_pending_q, clr_pending_d;
    logic           send_data_q, send_data_d, clear_frame_q, clear_frame_d;
    logic           fb_we_q, fb_we_d, frame_done_q, frame_done_d, overflow_q, overflow_d;
    logic [20:0]    fb_addr_q, fb_addr_d;
    logic [7:0]     fb_wdata_q, fb_wdata_d;
    logic [15:0]    frame_count_q, frame_count_d;
    logic           push, push_ok, pop, full, last, clr_fire;

    function automatic logic [7:0] map_colour(input logic [31:0] cnt);
        logic [7:0] c;
        c = cnt[7:0];
        if (cnt >= MAX_ITER) return 8'h00;
        if (cnt > 32'd255) return 8'hFF;
`ifdef PIXEL_WRITER_PALETTE_EN
        return {c[2:0], c[5:3], c[7:6]};
`else
        return c;
`endif
    endfunction

    // Word 0 arrives on the edge that leaves StGap, so capture starts there.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (eng_ready && ((CW'(FIFO_DEPTH) - count_q) >= CW'(SET_SIZE))) begin
                    state_d = StReq;
                end
            end
            StReq: state_d = StGap;
            StGap: begin
                push    = 1'b1;
                beat_d  = CW'(1);
                state_d = (SET_SIZE == 1) ? StIdle : StRecv;
            end
            StRecv: begin
                push   = 1'b1;
                beat_d = beat_q + CW'(1);
                if (beat_q == CW'(SET_SIZE - 1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        full    = (count_q == CW'(FIFO_DEPTH));
        push_ok = push && !full;
        pop     = (count_q != '0) && !fb_busy;

        count_d = count_q;
        if (push_ok && !pop) count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);

        wptr_d = wptr_q;
        if (push_ok) wptr_d = (wptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + AW'(1);
        rptr_d = rptr_q;
        if (pop) rptr_d = (rptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + AW'(1);

        // Address 0 starts a frame, so the size comes from the live input there.
        limit   = (pix_q == '0) ? total_pixels : total_q;
        last    = pop && (pix_q == limit - 21'd1);
        total_d = (pop && (pix_q == '0)) ? total_pixels : total_q;
        pix_d   = pix_q;
        if (pop) pix_d = last ? '0 : pix_q + 21'd1;

        clr_fire      = clr_pending_q && eng_frame_ready;
        clr_pending_d = clr_pending_q;
        if (clr_fire) clr_pending_d = 1'b0;
        if (last) clr_pending_d = 1'b1;

        send_data_d   = (state_d == StReq);
        clear_frame_d = clr_fire;
        fb_we_d       = pop;
        fb_addr_d     = pop ? pix_q : fb_addr_q;
        fb_wdata_d    = pop ? mem_q[rptr_q] : fb_wdata_q;
        frame_done_d  = last;
        frame_count_d = last ? frame_count_q + 16'd1 : frame_count_q;
        overflow_d    = overflow_q | (push && full);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            beat_q        <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            pix_q         <= '0;
            total_q       <= '0;
            clr_pending_q <= 1'b0;
            send_data_q   <= 1'b0;
            clear_frame_q <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_wdata_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            pix_q         <= pix_d;
            total_q       <= total_d;
            clr_pending_q <= clr_pending_d;
            send_data_q   <= send_data_d;
            clear_frame_q <= clear_frame_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_wdata_q    <= fb_wdata_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wptr_q] <= map_colour(eng_data);
    end

    assign send_data   = send_data_q;
    assign clear_frame = clear_frame_q;
    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_wdata    = fb_wdata_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;

endmodule
